equiv_sweep_checker: RTL and testbench
======================================

# equiv_sweep_checker

Sequential exhaustive-sweep equivalence checker for N-input single-output combinational circuits. It drives every input vector 0 … 2^N_IN−1 onto two circuit implementations, for example a NAND-only and a NOR-only realisation of the same function. It compares their outputs after a programmable settle time and reports the pass/fail verdict, the mismatch count and the first failing vector. It sits beside the gate-level function blocks as a reusable self-check engine, replacing hand-written per-vector stimulus lists.

## Interface
Parameters:
- N_IN, default 4: number of circuit inputs. Legal range is 1–16.
- SETTLE, default 1: extra cycles each vector is held before its outputs are sampled. Legal range is 0–255. Each vector occupies SETTLE+1 cycles.

Ports (clock and reset first):
- clk, input, 1: the single clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: starts a sweep. Accepted only in IDLE or DONE.
- abort, input, 1: cancels a running sweep and returns to IDLE.
- stop_on_fail, input, 1: mode select, latched when start is accepted. 1 means end the sweep at the first mismatch.
- vec, output, N_IN: stimulus vector, registered, wired to both implementations.
- f_a, input, 1: output of implementation A.
- f_b, input, 1: output of implementation B.
- busy, output, 1: high while a sweep is running.
- done, output, 1: level, high in DONE until the next start or abort.
- pass, output, 1: valid when done=1. Equals 1 iff mismatch_cnt==0.
- mismatch_cnt, output, N_IN+1: number of mismatching vectors. The extra bit holds the value 2^N_IN without wrap.
- first_fail, output, N_IN: first vector that mismatched.
- first_fail_vld, output, 1: high once first_fail holds a captured vector.

## Operation
- States are IDLE, RUN and DONE.
- Reset (rst_n=0, any state, mid-sweep included) puts the FSM in IDLE with vec=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail=0 and first_fail_vld=0. The settle counter and the latched mode are cleared.
- IDLE or DONE with start=1 (and abort=0):
  - Enter RUN and set busy=1, done=0, pass=0 and vec=0.
  - Clear mismatch_cnt, first_fail and first_fail_vld.
  - Latch stop_on_fail.
- RUN behaviour:
  - The settle counter counts 0…SETTLE. On the cycle where the count equals SETTLE, f_a/f_b are sampled at the next edge.
  - A sample is a mismatch when f_a !== f_b (4-state compare: X or Z on either input counts as a mismatch).
  - On a mismatch, mismatch_cnt increments. If first_fail_vld=0, first_fail is set to vec and first_fail_vld to 1.
  - If the sampled vector was 2^N_IN−1, or a mismatch occurred with latched stop_on_fail=1, enter DONE. Otherwise vec increments by 1 and the settle counter restarts at 0.
- Entering DONE sets busy=0, done=1, pass=(final mismatch_cnt==0) and vec=0. The counting includes the final sample.
- Wrap-around: vec never wraps inside a sweep. The all-ones vector is the last one sampled.
- abort=1 in RUN enters IDLE next edge and sets busy=0 and done=0. Result registers hold their partial values.
- Precedence and ignored inputs:
  - abort has priority over start and over the final-sample transition.
  - abort in IDLE or DONE is a no-op, except that it also clears done in DONE.
  - start while in RUN is ignored.

## Timing
- Let E0 be the edge that accepts start, and S=SETTLE.
  - busy=1 and vec=0 are visible after E0.
  - Vector k is driven from edge E0+k·(S+1) and sampled at edge E0+(k+1)·(S+1).
- A full sweep has done=1 after edge E0+2^N_IN·(S+1). The default is 32 cycles.
- With stop_on_fail, done rises at the same edge that samples the first mismatch.
- Result registers (mismatch_cnt, first_fail, first_fail_vld) update at the sampling edge. busy, done and pass update at the transition edge.
- The implementations must settle within S+1 cycles of vec changing. The checker does not detect settle violations.
- A back-to-back restart (start in DONE) begins a new sweep at that edge with no idle cycle.

## Test plan
- Equivalence: N_IN=4, S=1, f_a=f_b=vec[0]^vec[3], start pulse -> done=1 exactly 32 cycles after the start edge; pass=1, mismatch_cnt=0, first_fail_vld=0, vec=0.
- Single fault: f_b inverted only when vec==4'b1010, stop_on_fail=0 -> done after 32 cycles; pass=0, mismatch_cnt=1, first_fail=4'b1010, first_fail_vld=1.
- Stop-on-fail: f_b=~f_a, stop_on_fail=1 -> done=1 at edge E0+2; mismatch_cnt=1, first_fail=0, busy=0.
- All-fail, no wrap: f_b=~f_a, stop_on_fail=0, N_IN=4 -> mismatch_cnt=16 (5'b10000), first_fail=0.
- Abort and ignored start: start, then start again at cycle 5 (ignored; sweep timing unchanged), then abort at cycle 10 -> next edge IDLE, busy=0, done=0, vec=0 after a new start only.
- Reset mid-sweep: rst_n low asynchronously at cycle 7 -> all outputs immediately at reset values. A start after release performs a full 32-cycle sweep.

Source files
------------

// File: rtl/equiv_sweep_checker.sv
// Exhaustive-sweep equivalence checker: drives every input vector onto two
// implementations, compares their outputs after a settle time, and reports the verdict.
module equiv_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            stop_on_fail,
  output logic [N_IN-1:0] vec,
  input  logic            f_a,
  input  logic            f_b,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [7:0]      SETTLE_C = 8'(SETTLE);

  state_t      state;
  logic [7:0]  settle_cnt;
  logic        stop_lat;

  logic          sample;
  logic          mm;
  logic          finish;
  logic [N_IN:0] cnt_next;

  // Case-inequality so that X/Z on either implementation output counts as a mismatch.
  always_comb begin
    sample   = (state == RUN) && (settle_cnt == SETTLE_C);
    mm       = sample && (f_a !== f_b);
    cnt_next = mismatch_cnt + {{N_IN{1'b0}}, mm};
    finish   = sample && ((vec == LAST_VEC) || (mm && stop_lat));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      stop_lat       <= 1'b0;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
          end else if (start) begin
            state          <= RUN;
            settle_cnt     <= '0;
            stop_lat       <= stop_on_fail;
            vec            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            // Partial results are kept for inspection after an abort.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (sample) begin
            if (mm) begin
              mismatch_cnt <= cnt_next;
              if (!first_fail_vld) begin
                first_fail     <= vec;
                first_fail_vld <= 1'b1;
              end
            end
            if (finish) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (cnt_next == '0);
              vec   <= '0;
            end else begin
              vec        <= vec + 1'b1;
              settle_cnt <= '0;
            end
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Randomized self-checking bench for equiv_sweep_checker using truth-table driven
// implementations and a per-sweep reference model of count, first failure and timing.
module tb_equiv_sweep_checker;
  localparam int N_IN   = 4;
  localparam int SETTLE = 1;
  localparam int NV     = 1 << N_IN;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            stop_on_fail = 1'b0;
  logic [N_IN-1:0] vec;
  logic            f_a, f_b;
  logic            busy, done, pass;
  logic [N_IN:0]   mismatch_cnt;
  logic [N_IN-1:0] first_fail;
  logic            first_fail_vld;

  logic [NV-1:0]   tt_a, tt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign f_a = tt_a[vec];
  assign f_b = tt_b[vec];

  equiv_sweep_checker #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .stop_on_fail(stop_on_fail), .vec(vec), .f_a(f_a), .f_b(f_b),
    .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .first_fail(first_fail), .first_fail_vld(first_fail_vld)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".vec"}, int'(vec), 0);
    check_eq({tag, ".busy"}, int'(busy), 0);
    check_eq({tag, ".done"}, int'(done), 0);
    check_eq({tag, ".pass"}, int'(pass), 0);
    check_eq({tag, ".cnt"}, int'(mismatch_cnt), 0);
    check_eq({tag, ".ff"}, int'(first_fail), 0);
    check_eq({tag, ".ffv"}, int'(first_fail_vld), 0);
  endtask

  // Reference: walk the truth tables in vector order and derive the verdict directly.
  task automatic run_sweep(input string tag, input logic stop);
    int  exp_cnt, exp_ff, k_end, exp_cyc, cyc;
    bit  found;
    exp_cnt = 0; exp_ff = 0; found = 0; k_end = NV - 1;
    for (int v = 0; v < NV; v++) begin
      if (tt_a[v] !== tt_b[v]) begin
        exp_cnt++;
        if (!found) begin found = 1; exp_ff = v; end
        if (stop) begin k_end = v; break; end
      end
    end
    exp_cyc = (k_end + 1) * (SETTLE + 1);

    @(negedge clk);
    stop_on_fail = stop;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop_on_fail = ~stop;
    check_eq({tag, ".busy0"}, int'(busy), 1);
    check_eq({tag, ".vec0"}, int'(vec), 0);
    check_eq({tag, ".done0"}, int'(done), 0);
    cyc = 0;
    while (!done && cyc < exp_cyc + 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!done) check_eq({tag, ".vec"}, int'(vec), cyc / (SETTLE + 1));
    end
    check_eq({tag, ".cycles"}, cyc, exp_cyc);
    check_eq({tag, ".done"}, int'(done), 1);
    check_eq({tag, ".busy"}, int'(busy), 0);
    check_eq({tag, ".pass"}, int'(pass), (exp_cnt == 0) ? 1 : 0);
    check_eq({tag, ".cnt"}, int'(mismatch_cnt), exp_cnt);
    check_eq({tag, ".ffv"}, int'(first_fail_vld), found ? 1 : 0);
    check_eq({tag, ".ff"}, int'(first_fail), exp_ff);
    check_eq({tag, ".vec_end"}, int'(vec), 0);
  endtask

  initial begin
    int sel;
    tt_a = '0;
    tt_b = '0;
    #2;
    check_reset_vals("reset");
    #20;
    rst_n = 1'b1;

    // Equivalence: f = vec[0] ^ vec[3]
    for (int v = 0; v < NV; v++) begin
      tt_a[v] = v[0] ^ v[3];
    end
    tt_b = tt_a;
    run_sweep("equiv", 1'b0);

    // Single fault at 4'b1010, back-to-back restart from DONE
    tt_b = tt_a;
    tt_b[10] = ~tt_a[10];
    run_sweep("single", 1'b0);

    // Stop on the very first vector
    tt_b = ~tt_a;
    run_sweep("stopfail", 1'b1);

    // Every vector fails, count must reach 2^N_IN without wrap
    run_sweep("allfail", 1'b0);

    // Ignored start at cycle 5, abort at cycle 10
    tt_b = tt_a;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq("ign.busy", int'(busy), 1);
    check_eq("ign.vec5", int'(vec), 5 / (SETTLE + 1));
    repeat (4) @(posedge clk);
    #1 check_eq("ign.vec9", int'(vec), 9 / (SETTLE + 1));
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check_eq("abort.busy", int'(busy), 0);
    check_eq("abort.done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1 check_eq("abort.idle", int'(busy), 0);
    run_sweep("after_abort", 1'b0);

    // Asynchronous reset in the middle of a sweep
    tt_b = ~tt_a;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk); rst_n = 1'b1;
    tt_b = tt_a;
    tt_b[3] = ~tt_a[3];
    run_sweep("after_rst", 1'b0);

    // Randomized truth tables and fault patterns
    for (int i = 0; i < 12; i++) begin
      tt_a = NV'($urandom());
      sel = $urandom_range(0, 2);
      if (sel == 0) tt_b = tt_a;
      else if (sel == 1) begin
        tt_b = tt_a;
        tt_b[$urandom_range(0, NV - 1)] ^= 1'b1;
      end else tt_b = tt_a ^ NV'($urandom());
      run_sweep($sformatf("rand%0d", i), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
